// File: rtl/wb_trace_buffer_pkg.sv
// Shared pipeline types for the writeback trace buffer.
// Entry fields are sized for the widest supported core.
package wb_trace_buffer_pkg;

  localparam int DROP_CNT_WIDTH = 16;
  localparam int TRACE_RD_MAX   = 8;
  localparam int TRACE_DATA_MAX = 64;

  typedef struct packed {
    logic [TRACE_RD_MAX-1:0]   rd;
    logic [TRACE_DATA_MAX-1:0] data;
    logic [TRACE_DATA_MAX-1:0] pc;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_buffer_fifo_mem.sv
// Trace entry storage: one synchronous write port,
// one asynchronous read port.
module trace_fifo_mem
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  trace_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output trace_entry_t rdata
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace FIFO with drop counter and optional
// shadow register file (enabled by TRACE_SHADOW_RF_EN).
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 16,
  parameter int OVERWRITE      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      capture_en_i,
  input  logic                      wb_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  input  logic [DATA_WIDTH-1:0]     wb_pc_i,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic [REG_ADDR_WIDTH-1:0] rd_rd_o,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic [DATA_WIDTH-1:0]     rd_pc_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
  input  logic [REG_ADDR_WIDTH-1:0] probe_addr_i,
  output logic [DATA_WIDTH-1:0]     probe_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam bit RING = (OVERWRITE != 0);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;

  logic push, pop, full, empty;
  logic mem_we, evict, drop;
  logic count_inc, count_dec;
  trace_entry_t wr_entry;
  trace_entry_t rd_entry;
  logic unused_rd_entry;

  assign push  = wb_valid_i & capture_en_i
               & (wb_rd_i != '0);
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign pop   = !empty & rd_ready_i;

  // Full with no pop: ring mode evicts the oldest, else drop.
  assign drop   = push & full & !pop;
  assign evict  = drop & RING;
  assign mem_we = push & (!full | pop | RING);

  assign count_inc = push & !pop & !full;
  assign count_dec = pop & !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (mem_we) wr_ptr <= wr_ptr + PW'(1);
      if (pop | evict) rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        count_inc: count <= count + CW'(1);
        count_dec: count <= count - CW'(1);
        default:   count <= count;
      endcase
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
    end
  end

  assign wr_entry.rd   = TRACE_RD_MAX'(wb_rd_i);
  assign wr_entry.data = TRACE_DATA_MAX'(wb_data_i);
  assign wr_entry.pc   = TRACE_DATA_MAX'(wb_pc_i);

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign unused_rd_entry = ^rd_entry;

  assign rd_rd_o    = REG_ADDR_WIDTH'(rd_entry.rd);
  assign rd_data_o  = DATA_WIDTH'(rd_entry.data);
  assign rd_pc_o    = DATA_WIDTH'(rd_entry.pc);
  assign rd_valid_o = !empty;
  assign count_o    = count;
  assign full_o     = full;
  assign empty_o    = empty;
  assign drop_cnt_o = drop_cnt;

`ifdef TRACE_SHADOW_RF_EN
  localparam int NREGS = 2 ** REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] shadow_rf [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        shadow_rf[i] <= '0;
    end else if (wb_valid_i && wb_rd_i != '0) begin
      shadow_rf[wb_rd_i] <= wb_data_i;
    end
  end

  assign probe_data_o = (probe_addr_i == '0)
                      ? '0 : shadow_rf[probe_addr_i];
`else
  logic unused_probe;

  assign unused_probe = ^probe_addr_i;
  assign probe_data_o = '0;
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Randomized and directed bench for wb_trace_buffer:
// three configurations checked against a queue model.
module tb_wb_trace_buffer;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic capture_en;
  logic wb_valid;
  logic rd_ready;
  logic [4:0]  wb_rd;
  logic [4:0]  probe_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;

  logic [4:0]  cnt0;
  logic [2:0]  cnt1;
  logic [2:0]  cnt2;
  logic [4:0]  m_cnt   [3];
  logic        m_valid [3];
  logic        m_full  [3];
  logic        m_empty [3];
  logic [4:0]  m_rd    [3];
  logic [31:0] m_data  [3];
  logic [31:0] m_pc    [3];
  logic [31:0] m_probe [3];
  logic [15:0] m_drop  [3];

  ev_t mq [3][$];
  int mdrop [3];
  logic [31:0] sh [32];
  int mdepth [3] = '{16, 4, 4};
  bit mring  [3] = '{1'b0, 1'b0, 1'b1};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign m_cnt[0] = cnt0;
  assign m_cnt[1] = {2'b00, cnt1};
  assign m_cnt[2] = {2'b00, cnt2};

  wb_trace_buffer #(
    .DEPTH(16), .OVERWRITE(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .capture_en_i(capture_en),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
    .wb_data_i(wb_data), .wb_pc_i(wb_pc),
    .rd_valid_o(m_valid[0]), .rd_ready_i(rd_ready),
    .rd_rd_o(m_rd[0]), .rd_data_o(m_data[0]),
    .rd_pc_o(m_pc[0]), .count_o(cnt0),
    .full_o(m_full[0]), .empty_o(m_empty[0]),
    .drop_cnt_o(m_drop[0]),
    .probe_addr_i(probe_addr),
    .probe_data_o(m_probe[0])
  );

  wb_trace_buffer #(
    .DEPTH(4), .OVERWRITE(0)
  ) dut1 (
    .clk(clk), .rst(rst),
    .capture_en_i(capture_en),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
    .wb_data_i(wb_data), .wb_pc_i(wb_pc),
    .rd_valid_o(m_valid[1]), .rd_ready_i(rd_ready),
    .rd_rd_o(m_rd[1]), .rd_data_o(m_data[1]),
    .rd_pc_o(m_pc[1]), .count_o(cnt1),
    .full_o(m_full[1]), .empty_o(m_empty[1]),
    .drop_cnt_o(m_drop[1]),
    .probe_addr_i(probe_addr),
    .probe_data_o(m_probe[1])
  );

  wb_trace_buffer #(
    .DEPTH(4), .OVERWRITE(1)
  ) dut2 (
    .clk(clk), .rst(rst),
    .capture_en_i(capture_en),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
    .wb_data_i(wb_data), .wb_pc_i(wb_pc),
    .rd_valid_o(m_valid[2]), .rd_ready_i(rd_ready),
    .rd_rd_o(m_rd[2]), .rd_data_o(m_data[2]),
    .rd_pc_o(m_pc[2]), .count_o(cnt2),
    .full_o(m_full[2]), .empty_o(m_empty[2]),
    .drop_cnt_o(m_drop[2]),
    .probe_addr_i(probe_addr),
    .probe_data_o(m_probe[2])
  );

  task automatic drive(
    input bit          v,
    input bit          en,
    input logic [4:0]  rd,
    input logic [31:0] d,
    input logic [31:0] pc,
    input bit          rdy
  );
    wb_valid   = v;
    capture_en = en;
    wb_rd      = rd;
    wb_data    = d;
    wb_pc      = pc;
    rd_ready   = rdy;
  endtask

  // Advance one clock and apply the queue-level rules.
  task automatic tick();
    bit push;
    bit sh_we;
    bit r;
    bit pop [3];
    ev_t ev;
    push  = wb_valid && capture_en && wb_rd != 5'd0;
    sh_we = wb_valid && wb_rd != 5'd0;
    r     = rst;
    ev    = '{rd: wb_rd, data: wb_data, pc: wb_pc};
    for (int k = 0; k < 3; k++)
      pop[k] = rd_ready && mq[k].size() > 0;
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        mq[k].delete();
        mdrop[k] = 0;
      end
      for (int i = 0; i < 32; i++) sh[i] = '0;
    end else begin
      if (sh_we) sh[ev.rd] = ev.data;
      for (int k = 0; k < 3; k++) begin
        if (pop[k]) void'(mq[k].pop_front());
        if (push) begin
          if (mq[k].size() < mdepth[k]) begin
            mq[k].push_back(ev);
          end else begin
            if (mring[k]) begin
              void'(mq[k].pop_front());
              mq[k].push_back(ev);
            end
            if (mdrop[k] < 65535) mdrop[k]++;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 5'd0, 32'd0, 32'd0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (m_cnt[k] !== 5'd0 || m_empty[k] !== 1'b1
          || m_full[k] !== 1'b0
          || m_valid[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags dut%0d cnt=%0d e=%b f=%b v=%b exp 0/1/0/0",
                 k, m_cnt[k], m_empty[k], m_full[k], m_valid[k]);
      end
      checks++;
      if (m_drop[k] !== 16'd0) begin
        errors++;
        $display("FAIL reset_drop dut%0d got %0d exp 0",
                 k, m_drop[k]);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_d [3];
    exp_d = '{32'h11, 32'h22, 32'h33};
    do_reset();
    drive(1, 1, 5'd1, 32'h11, 32'h0, 0); tick();
    drive(1, 1, 5'd2, 32'h22, 32'h4, 0); tick();
    drive(1, 1, 5'd3, 32'h33, 32'h8, 0); tick();
    drive(0, 1, 5'd0, 32'h0, 32'h0, 0);
    checks++;
    if (cnt0 !== 5'd3) begin
      errors++;
      $display("FAIL basic_count got %0d exp 3", cnt0);
    end
    checks++;
    if (m_rd[0] !== 5'd1 || m_data[0] !== 32'h11
        || m_pc[0] !== 32'h0) begin
      errors++;
      $display("FAIL basic_head got x%0d/%h/%h exp x1/11/0",
               m_rd[0], m_data[0], m_pc[0]);
    end
    tick();
    checks++;
    if (m_data[0] !== 32'h11) begin
      errors++;
      $display("FAIL basic_hold got %h exp 11", m_data[0]);
    end
    drive(0, 1, 5'd0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_valid[0] !== 1'b1 || m_data[0] !== exp_d[i]
          || m_pc[0] !== 32'(4 * i)) begin
        errors++;
        $display("FAIL basic_pop%0d got v=%b %h@%h exp %h@%h",
                 i, m_valid[0], m_data[0], m_pc[0],
                 exp_d[i], 4 * i);
      end
      tick();
    end
    checks++;
    if (m_empty[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_empty got %b exp 1", m_empty[0]);
    end
  endtask

  task automatic test_filter();
    logic [4:0]  c0;
    logic [15:0] d0;
    do_reset();
    drive(1, 1, 5'd7, 32'h70, 32'h0, 0); tick();
    c0 = cnt0;
    d0 = m_drop[0];
    drive(1, 1, 5'd0, 32'h99, 32'h4, 0); tick();
    drive(1, 0, 5'd9, 32'h98, 32'h8, 0); tick();
    checks++;
    if (cnt0 !== c0 || cnt0 !== 5'(mq[0].size())) begin
      errors++;
      $display("FAIL filter_count got %0d exp %0d",
               cnt0, mq[0].size());
    end
    checks++;
    if (m_drop[0] !== d0 || m_drop[0] !== 16'd0) begin
      errors++;
      $display("FAIL filter_drop got %0d exp 0", m_drop[0]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      drive(1, 1, 5'(i), 32'(i), 32'(4 * i), 0);
      tick();
    end
    drive(0, 1, 5'd0, 32'd0, 32'd0, 0);
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (m_full[k] !== 1'b1 || m_drop[k] !== 16'd2) begin
        errors++;
        $display("FAIL ovf_state dut%0d full=%b drop=%0d exp 1/2",
                 k, m_full[k], m_drop[k]);
      end
    end
    drive(0, 1, 5'd0, 32'd0, 32'd0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_data[1] !== 32'(i + 1)) begin
        errors++;
        $display("FAIL ovf_stop_pop%0d got %0d exp %0d",
                 i, m_data[1], i + 1);
      end
      checks++;
      if (m_data[2] !== 32'(i + 3)) begin
        errors++;
        $display("FAIL ovf_ring_pop%0d got %0d exp %0d",
                 i, m_data[2], i + 3);
      end
      tick();
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] last [3];
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 5'd2, 32'(i), 32'd0, 0);
      tick();
    end
    drive(1, 1, 5'd5, 32'hAA, 32'h100, 1);
    tick();
    drive(0, 1, 5'd0, 32'd0, 32'd0, 1);
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (m_cnt[k] !== 5'd4 || m_drop[k] !== 16'd0) begin
        errors++;
        $display("FAIL fpp_state dut%0d cnt=%0d drop=%0d exp 4/0",
                 k, m_cnt[k], m_drop[k]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) last[k] = m_data[k];
      tick();
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (last[k] !== 32'hAA || m_empty[k] !== 1'b1) begin
        errors++;
        $display("FAIL fpp_last dut%0d got %h e=%b exp aa/1",
                 k, last[k], m_empty[k]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 5'd3, 32'(i), 32'd0, 0);
      tick();
    end
    checks++;
    if (m_drop[1] !== 16'd2) begin
      errors++;
      $display("FAIL fpp_predrop got %0d exp 2", m_drop[1]);
    end
    rst = 1'b1;
    drive(1, 1, 5'd7, 32'h77, 32'd0, 1);
    tick();
    rst = 1'b0;
    drive(0, 1, 5'd0, 32'd0, 32'd0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (m_empty[k] !== 1'b1 || m_drop[k] !== 16'd0) begin
        errors++;
        $display("FAIL mid_reset dut%0d e=%b drop=%0d exp 1/0",
                 k, m_empty[k], m_drop[k]);
      end
    end
  endtask

  task automatic test_shadow();
    logic [31:0] exp_p;
`ifdef TRACE_SHADOW_RF_EN
    exp_p = 32'hDEAD;
`else
    exp_p = 32'h0;
`endif
    do_reset();
    drive(1, 0, 5'd4, 32'hDEAD, 32'd0, 0);
    probe_addr = 5'd4;
    #1;
    checks++;
    if (m_probe[0] !== 32'h0) begin
      errors++;
      $display("FAIL shadow_rbw got %h exp 0", m_probe[0]);
    end
    tick();
    drive(0, 0, 5'd0, 32'd0, 32'd0, 0);
    #1;
    checks++;
    if (m_probe[0] !== exp_p || cnt0 !== 5'd0) begin
      errors++;
      $display("FAIL shadow_x4 got %h cnt=%0d exp %h/0",
               m_probe[0], cnt0, exp_p);
    end
    probe_addr = 5'd0;
    #1;
    checks++;
    if (m_probe[0] !== 32'h0) begin
      errors++;
      $display("FAIL shadow_x0 got %h exp 0", m_probe[0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_p;
    ev_t hd;
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 8,
            5'($urandom_range(0, 31)),
            $urandom, $urandom,
            $urandom_range(0, 9) < 4);
      probe_addr = 5'($urandom_range(0, 31));
      #1;
`ifdef TRACE_SHADOW_RF_EN
      exp_p = (probe_addr == 5'd0) ? 32'h0
                                   : sh[probe_addr];
`else
      exp_p = 32'h0;
`endif
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (m_cnt[k] !== 5'(mq[k].size())
            || m_full[k] !== (mq[k].size() == mdepth[k])
            || m_empty[k] !== (mq[k].size() == 0)
            || m_valid[k] !== (mq[k].size() != 0)) begin
          errors++;
          $display("FAIL rnd_state n=%0d dut%0d cnt=%0d f=%b e=%b v=%b exp cnt=%0d",
                   n, k, m_cnt[k], m_full[k], m_empty[k],
                   m_valid[k], mq[k].size());
        end
        checks++;
        if (m_drop[k] !== 16'(mdrop[k])) begin
          errors++;
          $display("FAIL rnd_drop n=%0d dut%0d got %0d exp %0d",
                   n, k, m_drop[k], mdrop[k]);
        end
        if (mq[k].size() > 0) begin
          hd = mq[k][0];
          checks++;
          if (m_rd[k] !== hd.rd || m_data[k] !== hd.data
              || m_pc[k] !== hd.pc) begin
            errors++;
            $display("FAIL rnd_head n=%0d dut%0d got x%0d/%h/%h exp x%0d/%h/%h",
                     n, k, m_rd[k], m_data[k], m_pc[k],
                     hd.rd, hd.data, hd.pc);
          end
        end
        checks++;
        if (m_probe[k] !== exp_p) begin
          errors++;
          $display("FAIL rnd_probe n=%0d dut%0d got %h exp %h",
                   n, k, m_probe[k], exp_p);
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    probe_addr = 5'd0;
    drive(0, 0, 5'd0, 32'd0, 32'd0, 0);
    for (int i = 0; i < 32; i++) sh[i] = '0;
    test_reset();
    test_basic();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_shadow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
